cobra_prog_loader: RTL and testbench

- Write-side counterpart of the CYBERcobra instruction fetch path. The core only reads instruction memory; this block fills it.
- Accepts a byte stream with a valid/ready handshake and parses a framed program image: length, words, checksum.
- Assembles 32-bit little-endian instruction words and issues one write per word to the instruction memory write port.
- Holds the core in reset while loading and reports done or error.

---
 rtl/cobra_prog_loader.sv | 142 ++++++++++++++
 tb/tb_cobra_prog_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cobra_prog_loader.sv
// Fills CYBERcobra instruction memory from a framed byte stream
// (len lo, len hi, 4*len data bytes LSB first, XOR checksum), holding the core in reset meanwhile.
module cobra_prog_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_o
);

    // Handshake: a byte transfers on a rising edge where byte_valid_i && byte_ready_o;
    // byte_ready_o is a flop, high only while a frame is being parsed.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_n;
    logic        ready_q, ready_n;
    logic        accept, start_ok, len_bad, last_word;
    logic [7:0]  len_lo_q, xor_q;
    logic [15:0] len_q, len_full, words_q;
    logic [23:0] word_q;
    logic [1:0]  byte_idx_q;
    logic        mem_we_q, cpu_rst_q, done_q, err_q;
    logic [31:0] mem_addr_q, mem_wd_q;

    assign accept    = byte_valid_i && ready_q;
    assign start_ok  = start_i && (state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign len_full  = {byte_i, len_lo_q};
    assign len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > 32'(MEM_WORDS));
    assign last_word = (byte_idx_q == 2'd3) && ((words_q + 16'd1) == len_q);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_n;
            ready_q <= ready_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start_i) state_n = S_LEN_LO;
            S_LEN_LO: if (accept) state_n = S_LEN_HI;
            S_LEN_HI: if (accept) state_n = len_bad ? S_ERROR : S_DATA;
            S_DATA:   if (accept && last_word) state_n = S_CHECK;
            S_CHECK:  if (accept) state_n = (byte_i == xor_q) ? S_DONE : S_ERROR;
            default:  state_n = S_IDLE;
        endcase
        ready_n = state_n inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_wd_q   <= 32'd0;
            cpu_rst_q  <= BOOT_HOLD;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= 16'd0;
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            xor_q      <= 8'd0;
            word_q     <= 24'd0;
            byte_idx_q <= 2'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (start_ok) begin
                cpu_rst_q  <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                words_q    <= 16'd0;
                xor_q      <= 8'd0;
                byte_idx_q <= 2'd0;
            end
            unique case (state_q)
                S_LEN_LO: if (accept) len_lo_q <= byte_i;
                S_LEN_HI: begin
                    if (accept) begin
                        len_q <= len_full;
                        if (len_bad) err_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        xor_q      <= xor_q ^ byte_i;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        unique case (byte_idx_q)
                            2'd0: word_q[7:0]   <= byte_i;
                            2'd1: word_q[15:8]  <= byte_i;
                            2'd2: word_q[23:16] <= byte_i;
                            default: begin
                                // Fourth lane completes the word: issue the write next cycle.
                                mem_wd_q   <= {byte_i, word_q};
                                mem_addr_q <= BASE_ADDR + {14'd0, words_q, 2'b00};
                                mem_we_q   <= 1'b1;
                                words_q    <= words_q + 16'd1;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (byte_i == xor_q) begin
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready_o = ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wd_o     = mem_wd_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign words_o      = words_q;

endmodule

// File: tb/tb_cobra_prog_loader.sv
// Directed and randomized frames for cobra_prog_loader, checked against an image-level
// reference (expected write list, XOR checksum, outcome flags).
module tb_cobra_prog_loader;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o, mem_we_o, cpu_rst_o, done_o, err_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic [15:0] words_o;

    int n_cmp = 0;
    int n_mis = 0;
    int stall_cnt = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] img[$];

    cobra_prog_loader #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(32'h0),
        .BOOT_HOLD(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .cpu_rst_o(cpu_rst_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    // Every cycle with mem_we_o high logs one write.
    always @(negedge clk) begin
        if (mem_we_o) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_wd_o);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
        check({tag, "_addr"}, mem_addr_o, 32'd0);
        check({tag, "_wd"}, mem_wd_o, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
        check({tag, "_words"}, {16'd0, words_o}, 32'd0);
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst_o}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int wait_cnt;
        repeat (gap) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            byte_i = 8'($urandom);
        end
        @(negedge clk);
        byte_i = b;
        byte_valid_i = 1'b1;
        wait_cnt = 0;
        while (!byte_ready_o && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
            stall_cnt++;
        end
        check("byte_ready_when_sending", {31'd0, byte_ready_o}, 32'd1);
        @(posedge clk);
    endtask

    // A stray valid byte during start must not be consumed (ready is low in IDLE/DONE/ERROR).
    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        byte_valid_i = 1'b1;
        byte_i = 8'hAA;
        @(negedge clk);
        start_i = 1'b0;
        byte_valid_i = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_addr_q.delete();
        exp_q.delete();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            check({tag, "_wr_addr"}, wr_addr_q[i], exp_addr_q[i]);
            check({tag, "_wr_data"}, wr_data_q[i], exp_q[i]);
        end
    endtask

    // Sends one frame built from img[] and checks outcome against the image-level model.
    task automatic run_load(input logic [15:0] len, input int gap_max, input bit flip_chk,
                            input string tag);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [31:0] w;
        bit          legal, good;
        legal = (len != 16'd0) && (int'(len) <= MEM_WORDS);
        good = legal && !flip_chk;
        chk = 8'd0;
        clear_logs();
        stall_cnt = 0;
        do_start();
        check({tag, "_start_ready"}, {31'd0, byte_ready_o}, 32'd1);
        check({tag, "_start_cpu_rst"}, {31'd0, cpu_rst_o}, 32'd1);
        check({tag, "_start_done"}, {30'd0, done_o, err_o}, 32'd0);
        check({tag, "_start_words"}, {16'd0, words_o}, 32'd0);
        send_byte(len[7:0], $urandom_range(0, gap_max));
        send_byte(len[15:8], $urandom_range(0, gap_max));
        if (legal) begin
            for (int i = 0; i < img.size(); i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) begin
                    b = w[8*k +: 8];
                    chk = chk ^ b;
                    send_byte(b, $urandom_range(0, gap_max));
                end
                exp_addr_q.push_back(32'(4 * i));
                exp_q.push_back(w);
            end
            send_byte(flip_chk ? (chk ^ 8'h01) : chk, $urandom_range(0, gap_max));
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        check({tag, "_done"}, {31'd0, done_o}, {31'd0, good});
        check({tag, "_err"}, {31'd0, err_o}, {31'd0, !good});
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst_o}, {31'd0, !good});
        check({tag, "_ready_after"}, {31'd0, byte_ready_o}, 32'd0);
        check({tag, "_words"}, {16'd0, words_o}, legal ? {16'd0, len} : 32'd0);
        repeat (2) @(negedge clk);
        check_writes(tag);
    endtask

    initial begin
        int n;
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        img.delete();
        img.push_back(32'h0000_0013);
        run_load(16'd1, 0, 1'b0, "single");

        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        run_load(16'd3, 0, 1'b0, "burst3");
        check("burst3_stalls", 32'(stall_cnt), 32'd0);

        run_load(16'd3, 0, 1'b1, "badchk");

        run_load(16'd0, 0, 1'b0, "len0");
        run_load(16'(MEM_WORDS + 1), 0, 1'b0, "len_over");
        img.delete();
        img.push_back($urandom);
        run_load(16'(MEM_WORDS + 1), 1, 1'b0, "len_over_again");

        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(1, 6);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            run_load(16'(n), 3, (t == 3), "rand");
        end

        // Reset in the middle of a 2-word load, after 6 data bytes.
        img.delete();
        img.push_back($urandom);
        img.push_back($urandom);
        clear_logs();
        do_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] w;
            w = img[k / 4];
            send_byte(w[8*(k%4) +: 8], $urandom_range(0, 1));
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        repeat (3) @(negedge clk);
        exp_addr_q.push_back(32'd0);
        exp_q.push_back(img[0]);
        check_writes("midreset");
        rst_i = 1'b1;
        @(negedge clk);
        run_load(16'd2, 1, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
